// File: rtl/tp_dis_loader_if.sv
// rtl/tp_dis_loader_if.sv - distance word stream in and table write bus out of tp_dis_loader
interface tp_dis_loader_if #(
  parameter int city_num_log = 5,
  parameter int dis_w        = 16
);
  // Upper-triangle distance stream from the host
  logic                      s_valid;
  logic [dis_w-1:0]          s_data;
  logic                      s_ready;

  // Table write bus broadcast to every replica node
  logic                      tp_dis_write;
  logic [2*city_num_log-1:0] tp_dis_waddr;
  logic [dis_w-1:0]          tp_dis_wdata;

  // Loader side
  modport master (
    input  s_valid, s_data,
    output s_ready, tp_dis_write, tp_dis_waddr, tp_dis_wdata
  );

  // Host / node side
  modport slave (
    output s_valid, s_data,
    input  s_ready, tp_dis_write, tp_dis_waddr, tp_dis_wdata
  );
endinterface

// File: rtl/tp_dis_loader.sv
// rtl/tp_dis_loader.sv - loads the symmetric two-point distance table into all nodes; optional TP_DIS_DIAG_ZERO_EN
module tp_dis_loader #(
  parameter int city_num     = 30,
  parameter int city_num_log = 5,
  parameter int dis_w        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  tp_dis_loader_if.master bus,
  output logic            busy,
  output logic            done
);

  localparam logic [city_num_log-1:0] LAST_IDX   = city_num_log'(city_num - 1);
  localparam logic [city_num_log-1:0] PENULT_IDX = city_num_log'(city_num - 2);
  localparam logic [city_num_log-1:0] ONE_IDX    = city_num_log'(1);
  localparam logic [city_num_log-1:0] TWO_IDX    = city_num_log'(2);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    REV,
    DIAG,
    FIN
  } state_t;

  state_t                    state_q, state_d;
  logic [city_num_log-1:0]   i_q, i_d;
  logic [city_num_log-1:0]   j_q, j_d;
  logic                      ready_q, ready_d;
  logic                      write_q, write_d;
  logic [2*city_num_log-1:0] waddr_q, waddr_d;
  logic [dis_w-1:0]          wdata_q, wdata_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  // Next state, index advance and the registered values of every output
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    write_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // done_q high means this is still the load's final cycle, so a start
        // arriving alongside done is dropped.
        if (start && !done_q) begin
          i_d     = '0;
          j_d     = ONE_IDX;
          state_d = ACCEPT;
        end
      end

      ACCEPT: begin
        if (bus.s_valid && ready_q) begin
          write_d = 1'b1;
          waddr_d = {i_q, j_q};
          wdata_d = bus.s_data;
          state_d = REV;
        end
      end

      REV: begin
        // Mirror write: wdata_q still holds the word captured in ACCEPT.
        write_d = 1'b1;
        waddr_d = {j_q, i_q};
        state_d = ACCEPT;
        if (i_q == PENULT_IDX && j_q == LAST_IDX) begin
          // Last pair: park the counters at their start values so they never
          // step past city_num-1.
          i_d = '0;
          j_d = ONE_IDX;
`ifdef TP_DIS_DIAG_ZERO_EN
          state_d = DIAG;
`else
          state_d = FIN;
`endif
        end else if (j_q == LAST_IDX) begin
          i_d = i_q + ONE_IDX;
          j_d = i_q + TWO_IDX;
        end else begin
          j_d = j_q + ONE_IDX;
        end
      end

`ifdef TP_DIS_DIAG_ZERO_EN
      DIAG: begin
        // Row counter doubles as the diagonal index k.
        write_d = 1'b1;
        waddr_d = {i_q, i_q};
        wdata_d = '0;
        if (i_q == LAST_IDX) begin
          i_d     = '0;
          state_d = FIN;
        end else begin
          i_d = i_q + ONE_IDX;
        end
      end
`endif

      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == ACCEPT);
    busy_d  = (state_d != IDLE);
  end

  // State, index counters and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= ONE_IDX;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      ready_q <= ready_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.s_ready      = ready_q;
  assign bus.tp_dis_write = write_q;
  assign bus.tp_dis_waddr = waddr_q;
  assign bus.tp_dis_wdata = wdata_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_tp_dis_loader.sv
// tb/tb_tp_dis_loader.sv - directed bench for tp_dis_loader with 4 cities
module tb_tp_dis_loader;

  localparam int CN = 4;
  localparam int CL = 2;
  localparam int DW = 16;
`ifdef TP_DIS_DIAG_ZERO_EN
  localparam int DIAG_N = 4;
`else
  localparam int DIAG_N = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  tp_dis_loader_if #(.city_num_log(CL), .dis_w(DW)) bus_if ();

  tp_dis_loader #(
    .city_num    (CN),
    .city_num_log(CL),
    .dis_w       (DW)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .start(start),
    .bus  (bus_if),
    .busy (busy),
    .done (done)
  );

  // {row,col} addresses and data of the 12 off-diagonal writes, in bus order
  logic [3:0] exp_addr [12] = '{4'h1, 4'h4, 4'h2, 4'h8, 4'h3, 4'hC,
                                4'h6, 4'h9, 4'h7, 4'hD, 4'hB, 4'hE};
  int         exp_data [12] = '{10, 10, 11, 11, 12, 12, 13, 13, 14, 14, 15, 15};
  logic [3:0] exp_diag [4]  = '{4'h0, 4'h5, 4'hA, 4'hF};

  int checks   = 0;
  int failures = 0;

  int         cyc_n   = 0;
  logic [3:0] w_addr [$];
  logic [15:0] w_data [$];
  int         w_cyc  [$];
  int         done_n  = 0;
  int         done_at = -1;
  int         ready_n = 0;
  int         hs_n    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc_n++;
    if (bus_if.tp_dis_write === 1'b1) begin
      w_addr.push_back(bus_if.tp_dis_waddr);
      w_data.push_back(bus_if.tp_dis_wdata);
      w_cyc.push_back(cyc_n);
    end
    if (done === 1'b1) begin
      done_n++;
      done_at = cyc_n;
    end
    if (bus_if.s_ready === 1'b1) ready_n++;
  end

  task automatic clear_mon();
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    done_n  = 0;
    done_at = -1;
    ready_n = 0;
    hs_n    = 0;
  endtask

  // One load: gap = idle cycles of s_valid after each handshake,
  // poke_at = words sent before a stray start, abort_at = words sent before reset in REV,
  // start_on_done = drive start in the done cycle.
  task automatic feed(input int gap, input int poke_at, input int abort_at, input bit start_on_done);
    int sent;
    int gc;
    int tail;
    bit poked;
    sent  = 0;
    gc    = 0;
    tail  = -1;
    poked = 1'b0;
    clear_mon();
    bus_if.s_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (abort_at >= 0 && sent == abort_at) begin
        check("abort_rev_write", bus_if.tp_dis_write, 1);
        check("abort_rev_waddr", bus_if.tp_dis_waddr, 4'h3);
        bus_if.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_write", bus_if.tp_dis_write, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", bus_if.s_ready, 0);
        return;
      end
      if (tail >= 0) begin
        if (tail == 0 && start_on_done) begin
          check("start_at_done_busy", busy, 0);
          check("start_at_done_ready", bus_if.s_ready, 0);
        end
        tail++;
        if (tail == 3) return;
      end
      if (done === 1'b1 && tail < 0) begin
        tail = 0;
        if (start_on_done) start = 1'b1;
      end
      if (poke_at >= 0 && sent == poke_at && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      bus_if.s_valid = (sent < 6) && (gc == 0);
      bus_if.s_data  = 16'(10 + sent);
      if (bus_if.s_valid && bus_if.s_ready === 1'b1) begin
        sent++;
        hs_n++;
        gc = gap;
      end else if (gc > 0) begin
        gc--;
      end
    end
    check("load_timeout", 0, 1);
  endtask

  task automatic check_writes(input string tag, input bit full_rate);
    int n_exp;
    logic [3:0]  ea;
    logic [15:0] ed;
    n_exp = 12 + DIAG_N;
    check({tag, "_count"}, w_addr.size(), n_exp);
    for (int k = 0; k < n_exp && k < w_addr.size(); k++) begin
      if (k < 12) begin
        ea = exp_addr[k];
        ed = 16'(exp_data[k]);
      end else begin
        ea = exp_diag[k-12];
        ed = 16'd0;
      end
      check($sformatf("%s_addr%0d", tag, k), w_addr[k], ea);
      check($sformatf("%s_data%0d", tag, k), w_data[k], ed);
      if (full_rate && k > 0)
        check($sformatf("%s_step%0d", tag, k), w_cyc[k] - w_cyc[k-1], 1);
    end
    check({tag, "_done_count"}, done_n, 1);
    if (w_cyc.size() > 0)
      check({tag, "_done_after_last"}, done_at, w_cyc[w_cyc.size()-1] + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_write", bus_if.tp_dis_write, 0);
    check("reset_waddr", bus_if.tp_dis_waddr, 0);
    check("reset_wdata", bus_if.tp_dis_wdata, 0);
    check("reset_ready", bus_if.s_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;

    // s_valid high in IDLE with no start
    @(negedge clk);
    clear_mon();
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 16'd99;
    repeat (6) @(negedge clk);
    check("idle_writes", w_addr.size(), 0);
    check("idle_ready", ready_n, 0);
    check("idle_busy", busy, 0);
    bus_if.s_valid = 1'b0;

    feed(0, -1, -1, 1'b0);
    check_writes("full", 1'b1);
    check("full_ready_cycles", ready_n, 6);
    check("full_handshakes", hs_n, 6);

    feed(2, -1, -1, 1'b0);
    check_writes("gap", 1'b0);
    check("gap_handshakes", hs_n, 6);

    feed(0, 2, -1, 1'b0);
    check_writes("poke", 1'b1);

    feed(0, -1, 3, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    feed(0, -1, -1, 1'b1);
    check_writes("after_reset", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
